idu_exu_seg_reg: RTL

//  Pipeline segment register between decode (IDU) and execute (EXU).

---
 rtl/idu_exu_seg_reg.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/idu_exu_seg_reg.sv
// IDU -> EXU pipeline segment register.
// Two-entry skid buffer: in_ready is a pure decode of registered state.
module idu_exu_seg_reg #(
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_inst,
    input  logic [31:0]       in_imm,
    input  logic              in_op_valid,
    input  logic [31:0]       in_rs1_data,
    input  logic [31:0]       in_rs2_data,
    input  logic [4:0]        in_rd,
    input  logic [CTRL_W-1:0] in_ctrl,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_inst,
    output logic [31:0]       out_imm,
    output logic [31:0]       out_rs1_data,
    output logic [31:0]       out_rs2_data,
    output logic [4:0]        out_rd,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_illegal,

    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       inst;
        logic [31:0]       imm;
        logic [31:0]       rs1_data;
        logic [31:0]       rs2_data;
        logic [4:0]        rd;
        logic [CTRL_W-1:0] ctrl;
        logic              illegal;
    } bundle_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t  state;
    state_t  state_nxt;
    bundle_t main_q;
    bundle_t skid_q;
    bundle_t in_bundle;

    logic in_fire;
    logic out_fire;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;
    logic stalled;

    assign in_bundle = '{
        pc:       in_pc,
        inst:     in_inst,
        imm:      in_imm,
        rs1_data: in_rs1_data,
        rs2_data: in_rs2_data,
        rd:       in_rd,
        ctrl:     in_ctrl,
        illegal:  ~in_op_valid
    };

    assign in_ready  = (state != SKID);
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign stalled   = out_valid & ~out_ready;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt    = FULL;
                        load_main_in = 1'b1;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        state_nxt = SKID;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                    end
                end
                SKID: begin
                    // in_ready is low here, so only the drain can happen
                    if (out_fire) begin
                        state_nxt      = FULL;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state <= state_nxt;
            if (load_main_in) begin
                main_q <= in_bundle;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_bundle;
            end
        end
    end

    // Flush deliberately leaves the counter alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stalled && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

    assign out_pc       = main_q.pc;
    assign out_inst     = main_q.inst;
    assign out_imm      = main_q.imm;
    assign out_rs1_data = main_q.rs1_data;
    assign out_rs2_data = main_q.rs2_data;
    assign out_rd       = main_q.rd;
    assign out_ctrl     = main_q.ctrl;
    assign out_illegal  = main_q.illegal;

endmodule
